// File: rtl/fft_output_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_output_reorder
// Function : Captures a 16-bin FFT frame in one beat. Streams it out in natural
//            bin order, undoing the butterfly bit-reversal.
// Revision : 1.0 - initial release
// ============================================================================
module fft_output_reorder #(
    parameter int DW     = 32,
    parameter bit BITREV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16*DW-1:0] in_real,
    input  logic [16*DW-1:0] in_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_real,
    output logic [DW-1:0]    out_imag,
    output logic [3:0]       out_index,
    output logic             out_last,
    output logic             frame_done
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [DW-1:0] r_bank_re [16];
    logic [DW-1:0] r_bank_im [16];
    logic [3:0]    r_cnt;
    logic          r_frame_done;
    logic [3:0]    w_rd_idx;
    logic          w_capture;
    logic          w_accept;
    logic          w_last_accept;

    generate
        if (BITREV) begin : g_bitrev
            assign w_rd_idx = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};
        end else begin : g_natural
            assign w_rd_idx = r_cnt;
        end
    endgenerate

    assign w_capture     = in_valid & in_ready;
    assign w_accept      = (r_state == S_STREAM) & out_ready;
    assign w_last_accept = w_accept & (r_cnt == 4'hF);
    assign frame_done    = r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_capture) w_state_nxt = S_STREAM;
            S_STREAM: if (w_last_accept && !in_valid) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // in_ready in STREAM only opens while bin 15 is being accepted, so a new
    // frame lands exactly as the old one finishes.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_index = 4'd0;
        out_last  = 1'b0;
        out_real  = '0;
        out_imag  = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_index = r_cnt;
                out_last  = (r_cnt == 4'hF);
                out_real  = r_bank_re[w_rd_idx];
                out_imag  = r_bank_im[w_rd_idx];
                in_ready  = (r_cnt == 4'hF) & out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_bank_re[i] <= '0;
                r_bank_im[i] <= '0;
            end
            r_cnt        <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_accept;
            if (w_capture) begin
                for (int i = 0; i < 16; i++) begin
                    r_bank_re[i] <= in_real[i*DW +: DW];
                    r_bank_im[i] <= in_imag[i*DW +: DW];
                end
                r_cnt <= 4'd0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire
